// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - multi-channel synchronised, glitch-filtered, qualified edge detector
module multi_edge_detector #(
    parameter int NUM_CH        = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         a_i,
    input  logic [NUM_CH-1:0]         en_i,
    input  logic [2*NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]         clr_i,
    output logic [NUM_CH-1:0]         level_o,
    output logic [NUM_CH-1:0]         rising_edge_o,
    output logic [NUM_CH-1:0]         falling_edge_o,
    output logic [NUM_CH-1:0]         pending_o,
    output logic                      irq_o,
    output logic [NUM_CH*CNT_W-1:0]   count_o
);

    localparam int               FCW       = $clog2(FILTER_CYCLES + 1);
    localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
    logic [FCW-1:0]    r_fcnt [NUM_CH];
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [NUM_CH-1:0] r_level;
    logic [NUM_CH-1:0] r_rise;
    logic [NUM_CH-1:0] r_fall;
    logic [NUM_CH-1:0] r_pend;

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_flip;
    logic [NUM_CH-1:0] w_qual;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= a_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    // A flip happens on the sample that would bring the mismatch run to FILTER_CYCLES.
    always_comb begin
        w_flip = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_flip[c] = (w_sync[c] != r_level[c]) && (r_fcnt[c] == FILT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) r_fcnt[c] <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_sync[c] == r_level[c] || w_flip[c])
                    r_fcnt[c] <= '0;
                else
                    r_fcnt[c] <= r_fcnt[c] + 1'b1;
            end
            r_level <= r_level ^ w_flip;
            r_rise  <= w_flip & ~r_level;
            r_fall  <= w_flip & r_level;
        end
    end

    always_comb begin
        w_qual = '0;
        for (int c = 0; c < NUM_CH; c++)
            w_qual[c] = en_i[c] & ((mode_i[2*c] & r_rise[c]) | (mode_i[2*c+1] & r_fall[c]));
    end

    // A clear coinciding with an event keeps that event: pending stays set, count restarts at 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend <= '0;
            for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
        end else begin
            r_pend <= (r_pend & ~clr_i) | w_qual;
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr_i[c])
                    r_cnt[c] <= CNT_W'(w_qual[c]);
                else if (w_qual[c] && r_cnt[c] != CNT_MAX)
                    r_cnt[c] <= r_cnt[c] + 1'b1;
            end
        end
    end

    always_comb begin
        count_o = '0;
        for (int c = 0; c < NUM_CH; c++)
            count_o[CNT_W*c +: CNT_W] = r_cnt[c];
    end

    assign level_o        = r_level;
    assign rising_edge_o  = r_rise;
    assign falling_edge_o = r_fall;
    assign pending_o      = r_pend;
    assign irq_o          = |r_pend;

endmodule

// File: tb/tb_multi_edge_detector.sv
// tb/tb_multi_edge_detector.sv - scoreboard bench for multi_edge_detector
module tb_multi_edge_detector;

    localparam int NCH  = 8;
    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  a_i, en_i, clr_i;
    logic [2*NCH-1:0] mode_i;
    logic [NCH-1:0]  level_o, rising_edge_o, falling_edge_o, pending_o;
    logic            irq_o;
    logic [NCH*CW-1:0] count_o;

    multi_edge_detector #(
        .NUM_CH(NCH), .SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .a_i(a_i), .en_i(en_i), .mode_i(mode_i), .clr_i(clr_i),
        .level_o(level_o), .rising_edge_o(rising_edge_o), .falling_edge_o(falling_edge_o),
        .pending_o(pending_o), .irq_o(irq_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]    lvl;
        logic [NCH-1:0]    rise;
        logic [NCH-1:0]    fall;
        logic [NCH-1:0]    pend;
        logic [NCH*CW-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    // Reference: a level flips once the last FILT filter samples all disagree with it.
    logic [NCH-1:0] m_sync [SYNC];
    logic [NCH-1:0] m_hist [FILT];
    logic [NCH-1:0] m_lvl, m_rise, m_fall, m_pend;
    logic [CW-1:0]  m_cnt [NCH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int c);
        return count_o[CW*c +: CW];
    endfunction

    task automatic model_edge();
        logic [NCH-1:0] s, mis, qual;
        exp_t e;
        if (!reset) begin
            for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
            for (int k = 0; k < FILT; k++) m_hist[k] = '0;
            for (int c = 0; c < NCH; c++) m_cnt[c] = '0;
            m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        end else begin
            s   = m_sync[SYNC-1];
            mis = s ^ m_lvl;
            for (int k = 0; k < FILT-1; k++) mis &= m_hist[k] ^ m_lvl;
            for (int c = 0; c < NCH; c++) begin
                qual[c] = en_i[c] & ((mode_i[2*c] & m_rise[c]) | (mode_i[2*c+1] & m_fall[c]));
                if (clr_i[c]) begin
                    m_pend[c] = qual[c];
                    m_cnt[c]  = qual[c] ? CW'(1) : CW'(0);
                end else if (qual[c]) begin
                    m_pend[c] = 1'b1;
                    if (m_cnt[c] != {CW{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
                end
            end
            m_rise = mis & ~m_lvl;
            m_fall = mis & m_lvl;
            m_lvl  = m_lvl ^ mis;
            for (int k = FILT-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = s;
            for (int k = SYNC-1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = a_i;
        end
        e.lvl = m_lvl; e.rise = m_rise; e.fall = m_fall; e.pend = m_pend;
        for (int c = 0; c < NCH; c++) e.cnt[CW*c +: CW] = m_cnt[c];
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("level",   32'(level_o),        32'(e.lvl));
        check_eq("rise",    32'(rising_edge_o),  32'(e.rise));
        check_eq("fall",    32'(falling_edge_o), 32'(e.fall));
        check_eq("pending", 32'(pending_o),      32'(e.pend));
        check_eq("irq",     32'(irq_o),          32'(|e.pend));
        check_eq("count",   32'(count_o),        32'(e.cnt));
    endtask

    initial begin
        int n_r, n_f;
        reset = 1'b0; a_i = 8'hFF; en_i = 8'hFF; mode_i = 16'h5555; clr_i = '0;
        repeat (3) cyc();
        check_eq("rst_level", 32'(level_o), 32'h0);
        check_eq("rst_count", 32'(count_o), 32'h0);

        // input held high through reset release: rising pulse at edge 5, pending/count at edge 6
        reset = 1'b1;
        repeat (5) cyc();
        check_eq("init_rise_early", 32'(rising_edge_o), 32'h00);
        cyc();
        check_eq("init_rise", 32'(rising_edge_o), 32'hFF);
        check_eq("init_pend_early", 32'(pending_o), 32'h00);
        cyc();
        check_eq("init_rise_1cyc", 32'(rising_edge_o), 32'h00);
        check_eq("init_pend", 32'(pending_o), 32'hFF);
        check_eq("init_count", 32'(count_o), 32'h1111_1111);

        a_i = '0;
        repeat (12) cyc();
        clr_i = 8'hFF; cyc(); clr_i = '0;

        // ch0: 3-sample glitch rejected, 4-sample pulse accepted
        n_r = 0;
        a_i[0] = 1'b1; repeat (3) cyc(); a_i[0] = 1'b0;
        repeat (12) begin cyc(); n_r += int'(rising_edge_o[0]); end
        check_eq("glitch3_rise", 32'(n_r), 32'd0);
        check_eq("glitch3_level", 32'(level_o[0]), 32'd0);
        n_r = 0;
        a_i[0] = 1'b1; repeat (4) cyc(); a_i[0] = 1'b0;
        repeat (16) begin cyc(); n_r += int'(rising_edge_o[0]); end
        check_eq("pulse4_rise", 32'(n_r), 32'd1);

        // ch2 falling-only, square wave period 20
        mode_i[5:4] = 2'b10; n_r = 0; n_f = 0;
        for (int p = 0; p < 3; p++) begin
            a_i[2] = 1'b1;
            repeat (10) begin cyc(); n_r += int'(rising_edge_o[2]); n_f += int'(falling_edge_o[2]); end
            a_i[2] = 1'b0;
            repeat (10) begin cyc(); n_r += int'(rising_edge_o[2]); n_f += int'(falling_edge_o[2]); end
        end
        check_eq("ch2_rise_pulses", 32'(n_r), 32'd3);
        check_eq("ch2_fall_pulses", 32'(n_f), 32'd3);
        check_eq("ch2_count", 32'(cnt_of(2)), 32'd3);

        // ch1 both edges: 20 events saturate a 4-bit counter
        mode_i[3:2] = 2'b11;
        for (int t = 0; t < 20; t++) begin
            a_i[1] = ~a_i[1];
            repeat (10) cyc();
        end
        check_eq("ch1_saturate", 32'(cnt_of(1)), 32'd15);

        // ch3: nine events, then clear coinciding with the tenth
        for (int p = 0; p < 9; p++) begin
            a_i[3] = 1'b1; repeat (10) cyc();
            a_i[3] = 1'b0; repeat (10) cyc();
        end
        check_eq("ch3_count9", 32'(cnt_of(3)), 32'd9);
        a_i[3] = 1'b1;
        for (int i = 0; i < 40 && !m_rise[3]; i++) cyc();
        check_eq("ch3_rise_seen", 32'(rising_edge_o[3]), 32'd1);
        clr_i = 8'h08; cyc(); clr_i = '0;
        check_eq("ch3_clr_evt_pend", 32'(pending_o[3]), 32'd1);
        check_eq("ch3_clr_evt_cnt", 32'(cnt_of(3)), 32'd1);
        a_i[3] = 1'b0; repeat (10) cyc();
        clr_i = 8'hFF; cyc(); clr_i = '0;
        check_eq("clr_all_irq", 32'(irq_o), 32'd0);
        check_eq("clr_all_cnt", 32'(count_o), 32'd0);

        // ch5 disabled: pulses still appear, nothing latched
        en_i[5] = 1'b0; n_r = 0; n_f = 0;
        a_i[5] = 1'b1;
        repeat (10) begin cyc(); n_r += int'(rising_edge_o[5]); n_f += int'(falling_edge_o[5]); end
        a_i[5] = 1'b0;
        repeat (10) begin cyc(); n_r += int'(rising_edge_o[5]); n_f += int'(falling_edge_o[5]); end
        check_eq("ch5_rise_pulses", 32'(n_r), 32'd1);
        check_eq("ch5_fall_pulses", 32'(n_f), 32'd1);
        check_eq("ch5_pending", 32'(pending_o[5]), 32'd0);
        check_eq("ch5_count", 32'(cnt_of(5)), 32'd0);

        // reset mid-filter on ch6 with input held high through it
        a_i[6] = 1'b1;
        repeat (4) cyc();
        reset = 1'b0; cyc();
        check_eq("midrst_level", 32'(level_o), 32'h0);
        reset = 1'b1;
        repeat (5) cyc();
        check_eq("midrst_no_early", 32'(rising_edge_o[6]), 32'd0);
        cyc();
        check_eq("midrst_rise", 32'(rising_edge_o[6]), 32'd1);
        repeat (4) cyc();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector: the next-generation replacement for the single-bit rising/falling detector. Each of NUM_CH asynchronous inputs is synchronised, glitch-filtered, and edge-detected. Detected edges are qualified by a per-channel mode and enable, latched into sticky pending flags, and counted in saturating per-channel counters. Sits between raw pins/status lines and the interrupt/status logic.

## Interface
- NUM_CH, 8, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per channel (1..4)
- FILTER_CYCLES, 4, consecutive mismatching samples required to accept a level change (1..255; 1 = no filtering)
- CNT_W, 8, per-channel event counter width (1..16)

- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- a_i  input  NUM_CH  raw asynchronous channel inputs
- en_i  input  NUM_CH  per-channel event enable
- mode_i  input  2*NUM_CH  per-channel mode, bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both
- clr_i  input  NUM_CH  write-1-to-clear pending flag and counter, single-cycle effect
- level_o  output  NUM_CH  filtered level per channel
- rising_edge_o  output  NUM_CH  one-cycle pulse on filtered 0->1
- falling_edge_o  output  NUM_CH  one-cycle pulse on filtered 1->0
- pending_o  output  NUM_CH  sticky qualified-event flags
- irq_o  output  1  OR of pending_o
- count_o  output  NUM_CH*CNT_W  per-channel saturating event counts, channel c at [CNT_W*c +: CNT_W]

## Operation
- Per channel pipeline: sync chain -> filter -> edge detect -> qualify -> pending/count.
- Filter: counter of width ceil(log2(FILTER_CYCLES+1)). Each cycle sync output != level: counter increments; when the increment would reach FILTER_CYCLES, level flips and counter returns to 0. Sync output == level: counter clears to 0. Glitches shorter than FILTER_CYCLES samples never reach level_o.
- Edge detect: rising_edge_o/falling_edge_o are registered and set in the same clock edge that level flips. Exactly one pulse per accepted transition; never both in one cycle.
- Qualified event = en_i[c] & ((mode bit0 & rise) | (mode bit1 & fall)). en_i/mode_i are sampled in the cycle the edge pulse is high.
- Disabled or mode 00 channels still filter and still drive level_o and edge pulses; only pending/count are masked.
- pending_o[c]: set on qualified event, cleared by clr_i[c]; simultaneous event and clear -> pending stays 1.
- count_o[c]: +1 per qualified event, saturates at 2^CNT_W-1 (no wrap); clr_i[c] -> 0; simultaneous event and clear -> loads 1.
- irq_o combinational OR of pending_o.

## Timing
- Reset (reset low at a clock edge): sync flops, filter counters, level_o, rising_edge_o, falling_edge_o, pending_o, count_o all 0; irq_o 0. Reset applied mid-filter or mid-pulse discards all state in that edge.
- Level starts at 0: an input held high through reset release is reported as a rising edge after normal latency.
- Latency: with the new a_i value first sampled at edge 0, level_o and the edge pulse update at edge SYNC_STAGES+FILTER_CYCLES-1; pulse high for exactly one cycle.
- pending_o and count_o update one edge after the edge pulse (edge SYNC_STAGES+FILTER_CYCLES).
- clr_i takes effect at the sampling edge; pending_o/count_o read 0 the following cycle.
- Channels fully independent; simultaneous events on any channel set are all captured.
- Minimum resolvable input period: 2*(FILTER_CYCLES) cycles between transitions; faster toggling yields no accepted edges.

## Test plan
- Defaults, reset held 3 cycles with a_i=0xFF -> all outputs 0 during reset; after release rising_edge_o=0xFF pulse at edge 5, pending_o=0xFF and count=1 each at edge 6 with en_i=0xFF, mode=01.
- Ch0 glitch high for 3 cycles (FILTER_CYCLES=4) -> level_o[0] stays 0, no pulse; 4-cycle high -> exactly one rising pulse.
- Ch2 mode=10, square wave period 20 -> falling pulses only counted; rising_edge_o still pulses; count increments once per period.
- CNT_W=4, 20 qualified edges on ch1 -> count_o[1] saturates at 15, never wraps.
- clr_i[3] in same cycle as qualified event on ch3 with pending=1,count=9 -> pending stays 1, count=1; clr alone next time -> 0,0, irq_o drops if no other pending.
- en_i[5]=0, edges on ch5 -> level_o/edge pulses toggle, pending_o[5]=0, count_o[5]=0; reset asserted mid-filter -> counter and level return to 0.
